sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO; the next-generation buffer for same-clock producer/consumer paths, where a two-clock FIFO adds needless synchroniser latency.
- Generalised in data width and depth, with a fill count, programmable almost-full/almost-empty thresholds, and a synchronous flush.
- Show-ahead read port: the head word is visible on rd_data before rd_en is asserted.

Parameters:
- DATA_W, 8, width of each stored word in bits.
- ADDR_W, 4, log2 of depth; DEPTH = 1 << ADDR_W (default 16).
- AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all FIFO contents.
- wr_en  input  1  write request.
- wr_data  input  DATA_W  write data.
- rd_en  input  1  read request; pops the head word.
- rd_data  output  DATA_W  head word (show-ahead).
- full  output  1  no free entries.
- empty  output  1  no stored entries.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  ADDR_W+1  number of stored words, 0..DEPTH.

Behaviour:
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits wide.
  - The low ADDR_W bits address memory; the MSB is the wrap flag.
  - Pointers increment modulo 2^(ADDR_W+1) and wrap naturally.
- count = wr_ptr - rd_ptr, computed modulo 2^(ADDR_W+1).
- empty = (wr_ptr == rd_ptr).
- full = (MSBs differ) and (low bits equal).
- almost_full and almost_empty are decoded from count.
- All status outputs are combinational from registered pointers, so they reflect an accepted operation in the cycle after the clock edge.
- Write accept: wr_en && !full.
  - mem[wr_ptr[ADDR_W-1:0]] <= wr_data; wr_ptr++.
  - When full, the write is dropped even if a read is accepted in the same cycle; there is no pass-through.
- Read accept: rd_en && !empty; rd_ptr++.
  - When empty, the read is ignored even if a write is accepted in the same cycle; there is no bypass.
- Simultaneous accepted write and read: both pointers advance and count is unchanged.
- rd_data = empty ? 0 : mem[rd_ptr[ADDR_W-1:0]].
  - A word written at edge N appears on rd_data after edge N when the FIFO was empty, i.e. 1-cycle write-to-read latency.
- flush: at the clock edge, both pointers are set to 0.
  - flush has priority over wr_en and rd_en in the same cycle; neither is accepted.
  - Memory contents are not cleared.
- Reset (rst_n low, asynchronous):
  - Pointers clear immediately, giving count=0, empty=1, full=0, almost_empty=1, almost_full=0 (for AF_LEVEL>=1) and rd_data=0.
  - Memory is not reset.
  - Reset mid-operation discards all contents; the first edge after rst_n deasserts accepts requests normally.
- Memory is inferred as a register array, with no RAM macro.

Optional Feature:
- Macro: SYNC_FIFO_ERR_EN.
- When defined, two extra outputs are added: overflow (1 bit) and underflow (1 bit).
  - overflow sets when wr_en && full at an edge (flush inactive).
  - underflow sets when rd_en && empty at an edge (flush inactive).
  - Both are sticky until reset or flush; both reset to 0.
  - Setting either flag does not alter FIFO state.
- When not defined, these ports do not exist and illegal requests are silently dropped.

Test Plan (defaults: DATA_W=8, ADDR_W=4, AF_LEVEL=14, AE_LEVEL=2):
- Reset then idle -> empty=1, full=0, count=0, almost_empty=1, almost_full=0, rd_data=0.
- Write 0x0A..0x19 (16 words) on consecutive cycles, no reads:
  - almost_empty deasserts after the 3rd write.
  - almost_full asserts after the 14th write.
  - full=1 and count=16 after the 16th write.
  - A 17th write of 0xFF is dropped (overflow=1 with SYNC_FIFO_ERR_EN).
- From full, read 16 times -> rd_data sequence 0x0A..0x19 in order, then empty=1 and rd_data=0. A 17th read leaves the pointers unchanged (underflow=1 with SYNC_FIFO_ERR_EN).
- Hold count=8, assert wr_en and rd_en together for 40 cycles with an incrementing pattern:
  - count stays at 8 throughout.
  - Pointers wrap twice.
  - Data order is preserved.
- With count=5, pulse flush together with wr_en and rd_en -> next cycle count=0, empty=1, no write stored; any error flags are cleared.
- With count=9, drop rst_n mid-cycle -> empty=1 and count=0 immediately, before the next clk edge. After release, write 0x42 -> rd_data=0x42 on the following cycle.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param -- single-clock parametrised FIFO with show-ahead read port.
//
// Purpose:
//   Same-clock producer/consumer buffer. It provides a fill count,
//   programmable almost-full/almost-empty thresholds and a synchronous flush.
//   The head word is presented on rd_data before rd_en is asserted.
//
// Parameters:
//   DATA_W    width of each stored word
//   ADDR_W    log2 of depth (DEPTH = 1 << ADDR_W)
//   AF_LEVEL  almost_full  when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  almost_empty when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset (clears pointers, not memory)
//   flush         synchronous clear of contents; overrides wr_en/rd_en
//   wr_en/wr_data write request and data; dropped when full
//   rd_en         pops the head word; ignored when empty
//   rd_data       head word, 0 while empty
//   full/empty    no free / no stored entries
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         stored words, 0..DEPTH
//
// Optional build macro SYNC_FIFO_ERR_EN:
//   Adds sticky overflow (write while full) and underflow (read while empty)
//   outputs. Both are cleared by reset or flush.
module sync_fifo_param #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count
`ifdef SYNC_FIFO_ERR_EN
   ,
   output logic              overflow,
   output logic              underflow
`endif
);

   localparam int              DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] AF_THR  = (ADDR_W+1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AE_THR  = (ADDR_W+1)'(AE_LEVEL);

   // Pointers carry one extra wrap bit so that full and empty are distinct
   // with all DEPTH entries usable.
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              wr_accept;
   logic              rd_accept;

   // Status decode from the registered pointers.
   always_comb begin
      empty        = (wr_ptr_q == rd_ptr_q);
      full         = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
      count        = wr_ptr_q - rd_ptr_q;
      almost_full  = (count >= AF_THR);
      almost_empty = (count <= AE_THR);
      rd_data      = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
   end

   // Accept decisions use the pre-edge full/empty. A write into a full FIFO
   // is dropped even if a read frees a slot in the same cycle, and a read
   // of an empty FIFO is ignored even if a write lands in the same cycle.
   always_comb begin
      wr_accept = wr_en && !full  && !flush;
      rd_accept = rd_en && !empty && !flush;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is a plain register array with no reset, because empty masks
   // stale contents on rd_data.
   always_ff @(posedge clk) begin
      if (wr_accept) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
   end

`ifdef SYNC_FIFO_ERR_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (flush) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_en && full)  overflow_d  = 1'b1;
         if (rd_en && empty) underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_comb begin
      overflow  = overflow_q;
      underflow = underflow_q;
   end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param (defaults: DATA_W=8, ADDR_W=4, AF=14, AE=2).
// The stimulus side keeps a queue-based reference FIFO. For each cycle it
// pushes the expected visible status and the expected popped words. A
// separate monitor process compares these against the DUT on the falling
// clock edge.
module tb_sync_fifo_param;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;
   localparam int AF_LEV = 14;
   localparam int AE_LEV = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              full, empty, almost_full, almost_empty;
   logic [ADDR_W:0]   count;
`ifdef SYNC_FIFO_ERR_EN
   logic              overflow, underflow;
`endif

   sync_fifo_param #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .AF_LEVEL(AF_LEV),
      .AE_LEVEL(AE_LEV)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .almost_empty(almost_empty),
      .count       (count)
`ifdef SYNC_FIFO_ERR_EN
      ,
      .overflow    (overflow),
      .underflow   (underflow)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int cnt;
      int head;
      bit ovf;
      bit unf;
   } st_t;

   // Reference model state.
   int   m_q[$];
   bit   m_ovf = 1'b0;
   bit   m_unf = 1'b0;

   // Scoreboard queues.
   st_t  st_q[$];
   int   exp_rd_q[$];

   bit   done = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   function automatic st_t model_status();
      st_t s;
      s.cnt  = m_q.size();
      s.head = (m_q.size() > 0) ? m_q[0] : 0;
      s.ovf  = m_ovf;
      s.unf  = m_unf;
      return s;
   endfunction

   // One clock cycle of stimulus. This task is entered at posedge+1.
   task automatic step(input bit f, input bit w, input int d, input bit r);
      bit wa, ra;
      flush   = f;
      wr_en   = w;
      wr_data = d[DATA_W-1:0];
      rd_en   = r;
      st_q.push_back(model_status());
      if (f) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         wa = w && (m_q.size() < DEPTH);
         ra = r && (m_q.size() > 0);
         if (w && m_q.size() == DEPTH) m_ovf = 1'b1;
         if (r && m_q.size() == 0)     m_unf = 1'b1;
         if (ra) exp_rd_q.push_back(m_q.pop_front());
         if (wa) m_q.push_back(d & 'hFF);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 0, 1'b0);
   endtask

   // Asserts reset partway through a cycle. It is released one cycle later.
   task automatic reset_mid();
      flush = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      #2;
      rst_n = 1'b0;
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      st_q.push_back(model_status());
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Stimulus
   initial begin
      int wprob;
      flush   = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      wr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Idle after reset
      idle();
      idle();

      // Fill with 0x0A..0x19, then one dropped write
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 'h0A + i, 1'b0);
      step(1'b0, 1'b1, 'hFF, 1'b0);
      idle();

      // Drain all 16 words, then one ignored read
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 0, 1'b1);
      step(1'b0, 1'b0, 0, 1'b1);
      idle();

      // Hold at 8 with concurrent read/write, so the pointers wrap
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, $urandom_range(0, 255), 1'b0);
      for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 'h80 + i, 1'b1);
      idle();

      // Reduce to 5, then flush with write and read asserted
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1);
      step(1'b1, 1'b1, 'h77, 1'b1);
      idle();

      // Reach 9 words, reset mid-cycle, then write 0x42
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, $urandom_range(0, 255), 1'b0);
      reset_mid();
      step(1'b0, 1'b1, 'h42, 1'b0);
      idle();

      // Randomized traffic with a bias that moves between fill and drain
      for (int blk = 0; blk < 8; blk++) begin
         wprob = (blk % 2 == 0) ? 80 : 20;
         for (int i = 0; i < 50; i++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 99) < wprob,
                 $urandom_range(0, 255),
                 $urandom_range(0, 99) < (100 - wprob));
         end
      end
      idle();
      done = 1'b1;
   end

   // Monitor: all comparisons are made here.
   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  nm, act, act, exp, exp, $time);
      end
   endtask

   initial begin
      st_t s;
      forever begin
         @(negedge clk or negedge rst_n);
         if (!rst_n && clk) begin
            // Reset must clear status before any clock edge.
            #1;
            chk("async_rst_empty", int'(empty), 1);
            chk("async_rst_count", int'(count), 0);
         end else begin
            if (st_q.size() > 0) begin
               s = st_q.pop_front();
               chk("count",        int'(count),        s.cnt);
               chk("empty",        int'(empty),        int'(s.cnt == 0));
               chk("full",         int'(full),         int'(s.cnt == DEPTH));
               chk("almost_full",  int'(almost_full),  int'(s.cnt >= AF_LEV));
               chk("almost_empty", int'(almost_empty), int'(s.cnt <= AE_LEV));
               chk("rd_data_head", int'(rd_data),      s.head);
`ifdef SYNC_FIFO_ERR_EN
               chk("overflow",     int'(overflow),     int'(s.ovf));
               chk("underflow",    int'(underflow),    int'(s.unf));
`endif
            end
            if (rst_n && rd_en && !flush && !empty) begin
               if (exp_rd_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL pop_unexpected: got 0x%0h, expected no read at %0t",
                           rd_data, $time);
               end else begin
                  chk("pop_data", int'(rd_data), exp_rd_q.pop_front());
               end
            end
            if (done) begin
               chk("leftover_reads", exp_rd_q.size(), 0);
               $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
               $finish;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
